// File: rtl/led_adc_pkg.sv
// Shared types and constants for the LED/ADC sequencer.
package led_adc_pkg;

    // Width of the phase counter; PHASE_CYCLES must fit in it (max 65535).
    localparam int unsigned CNT_W = 16;

    // 1 MHz clock: 5 ms per LED phase, 0.5 ms settle before sampling.
    localparam int unsigned DEF_PHASE_CYCLES  = 5000;
    localparam int unsigned DEF_SETTLE_CYCLES = 500;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/phase_timer.sv
// Phase counter: counts 0..PHASE_CYCLES-1 while running, wraps at terminal
// count, and flags the settle point and the terminal count of each phase.
module phase_timer
    import led_adc_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES  = DEF_PHASE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic settle_match,
    output logic terminal_count
);

    localparam cnt_t TC_VAL     = cnt_t'(PHASE_CYCLES - 1);
    localparam cnt_t SETTLE_VAL = cnt_t'(SETTLE_CYCLES - 1);

    cnt_t count_q;
    cnt_t count_d;

    // Next count: held at zero while parked, otherwise increment with wrap.
    always_comb begin
        // NOTE: assign a default first so every path drives count_d; a missing
        // branch would otherwise infer a latch.
        count_d = count_q;
        if (!run) begin
            count_d = '0;
        end else if (count_q == TC_VAL) begin
            count_d = '0;
        end else begin
            count_d = count_q + cnt_t'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples values from
        // before the edge; blocking ones would create order-dependent races.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign settle_match   = run && (count_q == SETTLE_VAL);
    assign terminal_count = run && (count_q == TC_VAL);

endmodule

// File: rtl/led_adc_sequencer.sv
// Alternates the IR and Red LEDs every phase, requests one ADC conversion per
// phase after the LED has settled, and stores each result into the channel of
// the LED that was lit. A conversion still outstanding at phase end is
// dropped and flagged in the sticky Overrun output.
module led_adc_sequencer
    import led_adc_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES  = DEF_PHASE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    output logic       ADC_Start,
    input  logic       ADC_Done,
    input  logic [7:0] ADC_Data,
    output logic       LED_IR,
    output logic       LED_Red,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] Red_ADC_Value,
    output logic       IR_Valid,
    output logic       Red_Valid,
    output logic       Overrun
);

    state_e     state_q,     state_d;
    logic       led_ir_q,    led_ir_d;
    logic       led_red_q,   led_red_d;
    logic       adc_start_q, adc_start_d;
    logic [7:0] ir_value_q,  ir_value_d;
    logic [7:0] red_value_q, red_value_d;
    logic       ir_valid_q,  ir_valid_d;
    logic       red_valid_q, red_valid_d;
    logic       overrun_q,   overrun_d;

    logic run;
    logic settle_match;
    logic terminal_count;

    // The timer only runs while the sequence is active; it restarts from 0
    // on every entry from IDLE.
    assign run = Enable && (state_q != ST_IDLE);

    phase_timer #(
        .PHASE_CYCLES  (PHASE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_phase_timer (
        .clk            (CLK),
        .rst            (RST),
        .run            (run),
        .settle_match   (settle_match),
        .terminal_count (terminal_count)
    );

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        led_ir_d    = led_ir_q;
        led_red_d   = led_red_q;
        adc_start_d = 1'b0;
        ir_value_d  = ir_value_q;
        red_value_d = red_value_q;
        ir_valid_d  = 1'b0;
        red_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (!Enable) begin
            // Park: LEDs off, any outstanding conversion abandoned silently.
            state_d   = ST_IDLE;
            led_ir_d  = 1'b0;
            led_red_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // IR is always the first phase after a start.
                    state_d   = ST_SETTLE;
                    led_ir_d  = 1'b1;
                    led_red_d = 1'b0;
                end
                ST_SETTLE: begin
                    if (settle_match) begin
                        state_d     = ST_START;
                        adc_start_d = 1'b1;
                    end
                end
                ST_START: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (ADC_Done) begin
                        state_d = ST_HOLD;
                        if (led_ir_q) begin
                            ir_value_d = ADC_Data;
                            ir_valid_d = 1'b1;
                        end else begin
                            red_value_d = ADC_Data;
                            red_valid_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Phase end overrides the state decode: a sample landing on this
            // very cycle was already accepted above, anything else pending is
            // an overrun.
            if (terminal_count) begin
                if (((state_q == ST_WAIT) && !ADC_Done) || (state_q == ST_START)) begin
                    overrun_d = 1'b1;
                end
                state_d     = ST_SETTLE;
                adc_start_d = 1'b0;
                led_ir_d    = led_red_q;
                led_red_d   = led_ir_q;
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            led_ir_q    <= 1'b0;
            led_red_q   <= 1'b0;
            adc_start_q <= 1'b0;
            ir_value_q  <= 8'h00;
            red_value_q <= 8'h00;
            ir_valid_q  <= 1'b0;
            red_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_ir_q    <= led_ir_d;
            led_red_q   <= led_red_d;
            adc_start_q <= adc_start_d;
            ir_value_q  <= ir_value_d;
            red_value_q <= red_value_d;
            ir_valid_q  <= ir_valid_d;
            red_valid_q <= red_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ADC_Start     = adc_start_q;
    assign LED_IR        = led_ir_q;
    assign LED_Red       = led_red_q;
    assign IR_ADC_Value  = ir_value_q;
    assign Red_ADC_Value = red_value_q;
    assign IR_Valid      = ir_valid_q;
    assign Red_Valid     = red_valid_q;
    assign Overrun       = overrun_q;

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Directed bench for led_adc_sequencer with a 20-cycle phase, 4-cycle settle
// and an ADC model that answers 3 cycles after each start request.
module tb_led_adc_sequencer;

    logic       CLK;
    logic       RST;
    logic       Enable;
    logic       ADC_Start;
    logic       ADC_Done;
    logic [7:0] ADC_Data;
    logic       LED_IR;
    logic       LED_Red;
    logic [7:0] IR_ADC_Value;
    logic [7:0] Red_ADC_Value;
    logic       IR_Valid;
    logic       Red_Valid;
    logic       Overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // ADC model and observation state
    int         cd          = 0;
    bit         adc_respond = 1'b1;
    logic [7:0] ir_data     = 8'h5A;
    logic [7:0] red_data    = 8'hA5;
    bit         both_seen   = 1'b0;
    int         ir_pulses   = 0;
    int         red_pulses  = 0;

    led_adc_sequencer #(
        .PHASE_CYCLES  (20),
        .SETTLE_CYCLES (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Enable        (Enable),
        .ADC_Start     (ADC_Start),
        .ADC_Done      (ADC_Done),
        .ADC_Data      (ADC_Data),
        .LED_IR        (LED_IR),
        .LED_Red       (LED_Red),
        .IR_ADC_Value  (IR_ADC_Value),
        .Red_ADC_Value (Red_ADC_Value),
        .IR_Valid      (IR_Valid),
        .Red_Valid     (Red_Valid),
        .Overrun       (Overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, then drive the
    // ADC model for the coming cycle.
    task automatic step();
        @(posedge CLK);
        #1;
        if (LED_IR && LED_Red) both_seen = 1'b1;
        if (IR_Valid)  ir_pulses++;
        if (Red_Valid) red_pulses++;
        ADC_Done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0 && adc_respond) begin
                ADC_Done = 1'b1;
                ADC_Data = LED_IR ? ir_data : red_data;
            end
        end
        if (ADC_Start) cd = 3;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RST      = 1'b1;
        Enable   = 1'b0;
        ADC_Done = 1'b0;
        ADC_Data = 8'h00;

        // Reset state
        steps(3);
        check("rst_flags", {ADC_Start, LED_IR, LED_Red, IR_Valid, Red_Valid, Overrun}, 6'b0);
        check("rst_ir_val", IR_ADC_Value, 8'h00);
        check("rst_red_val", Red_ADC_Value, 8'h00);

        // Normal IR then Red phase
        RST    = 1'b0;
        Enable = 1'b1;
        steps(1);
        check("first_leds", {LED_IR, LED_Red}, 2'b10);
        steps(4);
        check("adc_start", ADC_Start, 1'b1);
        steps(1);
        check("adc_start_1cyc", ADC_Start, 1'b0);
        steps(3);
        check("ir_valid", IR_Valid, 1'b1);
        check("ir_value", IR_ADC_Value, 8'h5A);
        steps(1);
        check("ir_valid_pulse", IR_Valid, 1'b0);
        steps(10);
        check("ir_phase_end", {LED_IR, LED_Red}, 2'b10);
        steps(1);
        check("red_phase_on", {LED_IR, LED_Red}, 2'b01);
        steps(8);
        check("red_valid", Red_Valid, 1'b1);
        check("red_value", Red_ADC_Value, 8'hA5);
        steps(12);
        check("back_to_ir", {LED_IR, LED_Red}, 2'b10);

        // Spurious ADC_Done in SETTLE and HOLD
        ir_data = 8'h11;
        steps(1);
        ADC_Done = 1'b1;
        ADC_Data = 8'hFF;
        steps(1);
        check("settle_spur_valid", {IR_Valid, Red_Valid}, 2'b00);
        check("settle_spur_val", IR_ADC_Value, 8'h5A);
        steps(6);
        check("ir_value_2", IR_ADC_Value, 8'h11);
        steps(2);
        ADC_Done = 1'b1;
        ADC_Data = 8'hFF;
        steps(1);
        check("hold_spur_valid", {IR_Valid, Red_Valid}, 2'b00);
        check("hold_spur_val", IR_ADC_Value, 8'h11);
        steps(9);
        check("red_phase_2", {LED_IR, LED_Red}, 2'b01);

        // ADC_Done on the terminal-count cycle of a Red phase
        adc_respond = 1'b0;
        steps(19);
        ADC_Done = 1'b1;
        ADC_Data = 8'h33;
        steps(1);
        check("tc_red_value", Red_ADC_Value, 8'h33);
        check("tc_red_valid", Red_Valid, 1'b1);
        check("tc_no_overrun", Overrun, 1'b0);
        check("tc_leds", {LED_IR, LED_Red}, 2'b10);

        // No response in an IR phase -> Overrun
        steps(19);
        check("overrun_before_end", Overrun, 1'b0);
        steps(1);
        check("overrun_set", Overrun, 1'b1);
        check("overrun_ir_held", IR_ADC_Value, 8'h11);
        check("overrun_leds", {LED_IR, LED_Red}, 2'b01);
        adc_respond = 1'b1;
        red_data    = 8'h3C;
        steps(8);
        check("after_overrun_red", Red_ADC_Value, 8'h3C);
        check("after_overrun_valid", Red_Valid, 1'b1);
        steps(12);
        check("overrun_sticky", Overrun, 1'b1);
        check("overrun_next_ir", {LED_IR, LED_Red}, 2'b10);

        // Reset mid-WAIT, late ADC_Done after release
        ir_data = 8'h77;
        steps(5);
        RST = 1'b1;
        steps(1);
        check("midrst_flags", {ADC_Start, LED_IR, LED_Red, IR_Valid, Red_Valid, Overrun}, 6'b0);
        check("midrst_ir_val", IR_ADC_Value, 8'h00);
        check("midrst_red_val", Red_ADC_Value, 8'h00);
        RST = 1'b0;
        steps(1);
        check("rst_release_led", {LED_IR, LED_Red}, 2'b10);
        steps(1);
        check("late_done_valid", IR_Valid, 1'b0);
        check("late_done_val", IR_ADC_Value, 8'h00);
        steps(7);
        check("restart_ir_val", IR_ADC_Value, 8'h77);
        check("restart_ir_valid", IR_Valid, 1'b1);

        // Enable dropped during WAIT in a Red phase
        red_data = 8'h99;
        steps(17);
        Enable = 1'b0;
        steps(1);
        check("disable_leds", {LED_IR, LED_Red, ADC_Start}, 3'b000);
        steps(2);
        check("disable_no_valid", Red_Valid, 1'b0);
        check("disable_red_val", Red_ADC_Value, 8'h00);
        check("disable_no_overrun", Overrun, 1'b0);
        Enable  = 1'b1;
        ir_data = 8'h42;
        steps(1);
        check("reenable_leds", {LED_IR, LED_Red}, 2'b10);
        steps(8);
        check("reenable_ir_val", IR_ADC_Value, 8'h42);
        check("reenable_ir_valid", IR_Valid, 1'b1);

        // Whole-run observations
        check("never_both_leds", both_seen, 1'b0);
        check("ir_pulse_count", ir_pulses, 4);
        check("red_pulse_count", red_pulses, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/led_adc_sequencer.md
LED_ADC_SEQUENCER -- requirements
Module: led_adc_sequencer

Interface
REQ-001 The block SHALL have parameter PHASE_CYCLES, default 5000, clock cycles per LED phase (5 ms at 1 MHz; IR+Red period 10 ms = 100 Hz).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 500, cycles after an LED switch before an ADC conversion starts; legal range 1..PHASE_CYCLES-3.
REQ-003 The block SHALL have port CLK  input  1  the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port Enable  input  1  high runs the IR/Red sequence; low parks the block.
REQ-006 The block SHALL have port ADC_Start  output  1  one-cycle conversion request to the ADC.
REQ-007 The block SHALL have port ADC_Done  input  1  one-cycle pulse, conversion complete, ADC_Data valid.
REQ-008 The block SHALL have port ADC_Data  input  8  unsigned conversion result.
REQ-009 The block SHALL have port LED_IR  output  1  infrared LED drive.
REQ-010 The block SHALL have port LED_Red  output  1  red LED drive.
REQ-011 The block SHALL have port IR_ADC_Value  output  8  last IR sample, held between updates; feeds the IR FIR input.
REQ-012 The block SHALL have port Red_ADC_Value  output  8  last Red sample, held between updates.
REQ-013 The block SHALL have port IR_Valid / Red_Valid  output  1 each  one-cycle pulse when the matching value updates; usable as the filter sample strobe.
REQ-014 The block SHALL have port Overrun  output  1  sticky: a conversion did not complete within its phase.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, START, WAIT, HOLD.
REQ-016 IDLE: LEDs off, phase counter 0; Enable high -> SETTLE with LED_IR=1 (IR phase always first).
REQ-017 Phase counter SHALL count 0..PHASE_CYCLES-1 from each phase start; at terminal count the active LED toggles, counter wraps to 0, FSM enters SETTLE.
REQ-018 SETTLE -> START when counter = SETTLE_CYCLES-1; START asserts ADC_Start for exactly one cycle, then WAIT.
REQ-019 WAIT: on ADC_Done, ADC_Data SHALL be registered into the value of the currently lit LED, with its Valid pulsed, one cycle after ADC_Done; FSM -> HOLD.
REQ-020 HOLD: idle until terminal count; exactly one conversion per phase.
REQ-021 ADC_Done outside WAIT SHALL be ignored (no value change, no Valid).
REQ-022 Terminal count while in WAIT without ADC_Done: sample discarded, Overrun set, LED toggles normally.
REQ-023 ADC_Done in the same cycle as terminal count in WAIT: sample accepted for the ending phase's channel, no Overrun, then toggle.
REQ-024 LED_IR and LED_Red SHALL never be high simultaneously; both low in IDLE.
REQ-025 Enable low in any state: next cycle IDLE, LEDs off, any pending conversion abandoned without Overrun; held values and Overrun retained.
REQ-026 Overrun SHALL clear only on RST.
REQ-027 Counter width SHALL be 16 bits; PHASE_CYCLES max 65535.

Reset
REQ-028 On RST high at a rising CLK edge: state IDLE, counter 0, ADC_Start 0, LED_IR 0, LED_Red 0, IR_ADC_Value 0, Red_ADC_Value 0, IR_Valid 0, Red_Valid 0, Overrun 0.
REQ-029 RST mid-conversion SHALL abandon it; a late ADC_Done after reset release SHALL be ignored (FSM not in WAIT).
REQ-030 After RST release with Enable high, the first LED_IR assertion SHALL occur one cycle later (via IDLE).

Structure
REQ-031 Shared package led_adc_pkg SHALL hold the FSM state enum, default PHASE_CYCLES/SETTLE_CYCLES, and the counter width constant.
REQ-032 Sub-module phase_timer (counter with wrap, settle-match and terminal-count flags) SHALL be instantiated once; FSM and sample registers stay in led_adc_sequencer.

Verification (PHASE_CYCLES=20, SETTLE_CYCLES=4, ADC responds 3 cycles after ADC_Start)
REQ-033 Enable high, ADC returns 0x5A in IR phase, 0xA5 in Red -> IR_ADC_Value=0x5A with IR_Valid pulse, Red_ADC_Value=0xA5 with Red_Valid pulse, LEDs toggle every 20 cycles, never both high.
REQ-034 ADC never responds in one IR phase -> Overrun=1 at that phase end, IR_ADC_Value unchanged, next Red phase samples normally, Overrun stays 1.
REQ-035 ADC_Done with 0x33 on the terminal-count cycle of a Red phase -> Red_ADC_Value=0x33, Overrun=0, LED_IR=1 next phase.
REQ-036 Spurious ADC_Done (0xFF) during SETTLE and HOLD -> no value change, no Valid.
REQ-037 Enable dropped during WAIT, then ADC_Done -> LEDs off next cycle, sample ignored, Overrun=0; re-enable restarts with IR phase.
REQ-038 RST asserted mid-WAIT -> all outputs 0 next cycle; ADC_Done arriving after release ignored.
